// File: rtl/sram_mask_clr.sv
// sram_mask_clr
//   Single-port synchronous SRAM model with per-byte write masking, a
//   registered read path of 1 or 2 cycles latency with a read-valid strobe,
//   and a clear sequencer that zero-fills every word after reset.
//
// Ports
//   CLK      clock, rising edge
//   reset    synchronous active-high reset; restarts the clear sequence
//   CEN      chip enable, active low
//   WEN      write enable, active low (1 = read, 0 = write)
//   A        word address
//   D        write data
//   BWEN     per-byte write enable, active low; bit i covers D[8i+7:8i]
//   Q        registered read data, holds between reads
//   Q_VALID  one-cycle pulse per read result on Q
//   BUSY     clear sequence running; requests are dropped while high
//
// States
//   CLEAR | zero-filling word[ptr] each cycle, requests ignored
//   IDLE  | serving read / write requests

module sram_mask_clr #(
  parameter int WIDTH  = 64,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int RD_LAT = 1
) (
  input  logic                 CLK,
  input  logic                 reset,
  input  logic                 CEN,
  input  logic                 WEN,
  input  logic [ADDR_W-1:0]    A,
  input  logic [WIDTH-1:0]     D,
  input  logic [WIDTH/8-1:0]   BWEN,
  output logic [WIDTH-1:0]     Q,
  output logic                 Q_VALID,
  output logic                 BUSY
);

  localparam int NB = WIDTH / 8;
  localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic [WIDTH-1:0]  mem [DEPTH];

  logic              in_range;
  logic              req_ok;
  logic              wr_en;
  logic              rd_en;
  logic [WIDTH-1:0]  rd_word;

  // Addresses at or beyond DEPTH only exist when DEPTH is not a power of two.
  assign in_range = ({1'b0, A} < DEPTH_X);
  assign req_ok   = (state == IDLE) && !CEN;
  assign wr_en    = req_ok && !WEN && in_range;
  assign rd_en    = req_ok && WEN;
  assign rd_word  = in_range ? mem[A] : '0;

  // Clear sequencer. BUSY is registered and drops together with the move to
  // IDLE, so its falling edge lines up with the first accepted request.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state <= CLEAR;
      ptr   <= '0;
      BUSY  <= 1'b1;
    end else if (state == CLEAR) begin
      if (ptr == LAST) begin
        state <= IDLE;
        ptr   <= '0;
        BUSY  <= 1'b0;
      end else begin
        ptr <= ptr + 1'b1;
      end
    end
  end

  // Array storage. No write happens in a reset cycle; the sequencer performs
  // the zero-fill afterwards.
  always_ff @(posedge CLK) begin
    if (!reset) begin
      if (state == CLEAR) begin
        mem[ptr] <= '0;
      end else if (wr_en) begin
        for (int i = 0; i < NB; i++) begin
          if (!BWEN[i]) mem[A][8*i +: 8] <= D[8*i +: 8];
        end
      end
    end
  end

  // Read pipeline. Q only loads when a result emerges, so later writes to the
  // same word do not disturb the value already on Q.
  generate
    if (RD_LAT == 1) begin : g_lat1
      always_ff @(posedge CLK) begin
        if (reset) begin
          Q       <= '0;
          Q_VALID <= 1'b0;
        end else begin
          Q_VALID <= rd_en;
          if (rd_en) Q <= rd_word;
        end
      end
    end else begin : g_lat2
      logic             s1_v;
      logic [WIDTH-1:0] s1_d;

      always_ff @(posedge CLK) begin
        if (reset) begin
          s1_v    <= 1'b0;
          s1_d    <= '0;
          Q       <= '0;
          Q_VALID <= 1'b0;
        end else begin
          s1_v    <= rd_en;
          if (rd_en) s1_d <= rd_word;
          Q_VALID <= s1_v;
          if (s1_v) Q <= s1_d;
        end
      end
    end
  endgenerate

endmodule

// File: doc/sram_mask_clr.md
# sram_mask_clr

Parametrised single-port synchronous SRAM model that succeeds the fixed 64-bit × 16-entry macro model used by the PE-array and activation/weight buffers. It has:
- configurable width and depth;
- per-byte write masking;
- a registered read path with selectable latency and a read-valid strobe;
- a hardware clear sequencer that zero-fills the whole array after reset.

Buffer controllers instantiate it wherever a memory must start in a known state, and must hold off traffic while BUSY is high.

## Interface
Parameters:
- WIDTH, 64, data word width in bits; must be a multiple of 8.
- DEPTH, 16, number of words; any value ≥ 2, not required to be a power of two.
- ADDR_W, 4, address width; must equal ceil(log2(DEPTH)).
- RD_LAT, 1, read latency in cycles; legal values are 1 and 2.

Ports:
- CLK  input  1  clock; all logic samples on the rising edge.
- reset  input  1  synchronous, active-high reset.
- CEN  input  1  chip enable, active low.
- WEN  input  1  write enable, active low; 1 = read, 0 = write.
- A  input  ADDR_W  word address.
- D  input  WIDTH  write data.
- BWEN  input  WIDTH/8  per-byte write enable, active low; bit i covers D[8i+7:8i].
- Q  output  WIDTH  read data, registered; holds its value between reads.
- Q_VALID  output  1  one-cycle pulse marking new read data on Q.
- BUSY  output  1  clear sequence in progress; requests are ignored while high.

## Operation
- State machine has two states, CLEAR and IDLE.
- **CLEAR state:**
  - Any cycle with reset = 1 forces CLEAR with clear pointer = 0; no array write happens in that cycle.
  - With reset = 0 in CLEAR, word[ptr] is written to 0 and ptr increments each cycle.
  - After word DEPTH-1 is written, the state moves to IDLE. The last write happens in cycle DEPTH-1, counted from the first cycle with reset low.
  - CEN, WEN, A, D and BWEN are fully ignored in CLEAR. A request presented then is dropped, not queued.
- **IDLE state, write** (CEN = 0, WEN = 0): for each i with BWEN[i] = 0, word[A] byte i ← D byte i. Bytes with BWEN[i] = 1 keep their old value. BWEN all-ones makes the write a no-op.
- **IDLE state, read** (CEN = 0, WEN = 1): word[A] is captured into the read pipeline. Q changes only when read data emerges from the pipeline, so later writes to the same address do not alter Q.
- **Idle cycle** (CEN = 1): no array change; Q holds.
- **Out-of-range address** (A ≥ DEPTH, possible only when DEPTH is not a power of two): a write is discarded; a read returns all zeros with a normal Q_VALID pulse.
- **Single port:** read and write cannot occur in the same cycle. A read in the cycle after a write to the same address returns the newly written data.
- **Reset mid-operation:** the pipeline is flushed, so Q_VALID is 0 and no pending read data is delivered. Q is cleared to 0 and the clear sequence restarts from word 0.

## Timing
- Values during and after reset:
  - During reset and in the cycle after it: Q = 0, Q_VALID = 0, BUSY = 1.
  - BUSY stays 1 for exactly DEPTH cycles after reset falls.
  - The first request is accepted in cycle DEPTH after reset deassertion.
- RD_LAT = 1: a read accepted at edge k updates Q and raises Q_VALID after edge k. Both are visible during cycle k+1; Q_VALID falls after edge k+1 unless another read was accepted at edge k+1.
- RD_LAT = 2: the same, but Q and Q_VALID appear one cycle later, during cycle k+2.
- Back-to-back reads give one Q word per cycle, in order, with Q_VALID held high continuously.
- Writes complete at the accepting edge and are visible to a read accepted at the next edge.
- BUSY is a registered output. Its falling edge coincides with the cycle in which the first request is accepted.

## Test plan
- **Reset clear:** fill all 16 words with 64'hFFFF_FFFF_FFFF_FFFF, then assert reset for 3 cycles. Check that BUSY stays high for exactly 16 cycles after release, then reading every address returns 0 with one Q_VALID pulse each.
- **Byte mask:** write 64'h1122_3344_5566_7788 to A = 5 with BWEN = 8'h00, then write 64'hAAAA_AAAA_AAAA_AAAA with BWEN = 8'hF0. A read of A = 5 must return 64'h1122_3344_AAAA_AAAA.
- **Latency and hold:**
  - RD_LAT = 1: read A = 3 (holding 64'hDEAD) → Q = 64'hDEAD with Q_VALID = 1 exactly one cycle later.
  - After that, write A = 3 ← 0 → Q still reads 64'hDEAD.
  - RD_LAT = 2: the same read → Q and Q_VALID one cycle later than with RD_LAT = 1.
- **Streaming:** with RD_LAT = 2, issue consecutive reads of A = 0..15 holding data A×3. Check 16 consecutive Q_VALID cycles with Q = 0, 3, 6 … 45, in order.
- **Ignore while busy / odd depth:**
  - With DEPTH = 10, ADDR_W = 4: a write issued during BUSY is dropped, so address 2 reads 0 afterwards.
  - A write to A = 12 is discarded, and a read of A = 12 returns 0 with Q_VALID = 1.
- **Reset mid-read:** issue a read with RD_LAT = 2, then assert reset on the next edge → Q_VALID never pulses, Q = 0, and BUSY = 1.
